// File: rtl/ooo_pkg.sv
// Shared out-of-order issue definitions: default widths, the instruction payload
// struct and the one-hot register decoder used by the scoreboard logic.
package ooo_pkg;

    localparam int unsigned NUM_REG     = 8;
    localparam int unsigned REG_ID_BIT  = $clog2(NUM_REG);
    localparam int unsigned INST_ID_BIT = 8;
    localparam int unsigned IMM_BIT     = 4;

    // Decoder is sized for the largest supported register file; callers truncate.
    localparam int unsigned DEC_MAX     = 64;
    localparam int unsigned DEC_ID_BIT  = 6;

    typedef struct packed {
        logic [INST_ID_BIT-1:0] id;
        logic [REG_ID_BIT-1:0]  dst;
        logic [REG_ID_BIT-1:0]  src0;
        logic [REG_ID_BIT-1:0]  src1;
        logic [IMM_BIT-1:0]     imm;
    } inst_t;

    function automatic logic [DEC_MAX-1:0] decode(input logic [DEC_ID_BIT-1:0] idx);
        logic [DEC_MAX-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/issue_scoreboard_hazard_check.sv
// Combinational RAW/WAW/WAR detection for the FIFO head against the busy vector
// and the pending reads of the other issue queues. Register 0 never hazards.
module hazard_check
    import ooo_pkg::*;
#(
    parameter int unsigned NUM_REG    = ooo_pkg::NUM_REG,
    parameter int unsigned REG_ID_BIT = $clog2(NUM_REG)
) (
    input  logic [NUM_REG-1:0]    busy,
    input  logic [NUM_REG-1:0]    ext_pending_read,
    input  logic [REG_ID_BIT-1:0] dst,
    input  logic [REG_ID_BIT-1:0] src0,
    input  logic [REG_ID_BIT-1:0] src1,
    output logic                  raw,
    output logic                  waw,
    output logic                  war
);

    logic [NUM_REG-1:0] nz_mask;
    logic [NUM_REG-1:0] dst_oh;
    logic [NUM_REG-1:0] src0_oh;
    logic [NUM_REG-1:0] src1_oh;

    always_comb begin
        nz_mask = ~NUM_REG'(1);
        dst_oh  = NUM_REG'(decode(DEC_ID_BIT'(dst)))  & nz_mask;
        src0_oh = NUM_REG'(decode(DEC_ID_BIT'(src0))) & nz_mask;
        src1_oh = NUM_REG'(decode(DEC_ID_BIT'(src1))) & nz_mask;
        raw     = |(busy & (src0_oh | src1_oh));
        waw     = |(busy & dst_oh);
        war     = |(ext_pending_read & dst_oh);
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate behind one issue_fifo, with a 1-entry output register.
// Optional macro ISSUE_SCOREBOARD_WB_BYPASS_EN: same-cycle writeback bypass into the hazard check.
module issue_scoreboard
    import ooo_pkg::*;
#(
    parameter int unsigned INST_ID_BIT   = ooo_pkg::INST_ID_BIT,
    parameter int unsigned NUM_REG       = ooo_pkg::NUM_REG,
    parameter int unsigned IMM_BIT       = ooo_pkg::IMM_BIT,
    parameter int unsigned REG_ID_BIT    = $clog2(NUM_REG),
    parameter int unsigned STALL_CNT_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [INST_ID_BIT-1:0]   in_id,
    input  logic [IMM_BIT-1:0]       in_imm,
    input  logic [REG_ID_BIT-1:0]    in_dst_reg,
    input  logic [REG_ID_BIT-1:0]    in_src_reg0,
    input  logic [REG_ID_BIT-1:0]    in_src_reg1,
    input  logic [NUM_REG-1:0]       ext_pending_read,
    input  logic                     wb_vld,
    input  logic [REG_ID_BIT-1:0]    wb_reg,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [INST_ID_BIT-1:0]   out_id,
    output logic [REG_ID_BIT-1:0]    out_dst_reg,
    output logic [REG_ID_BIT-1:0]    out_src_reg0,
    output logic [REG_ID_BIT-1:0]    out_src_reg1,
    output logic [IMM_BIT-1:0]       out_imm,
    output logic [NUM_REG-1:0]       reg_busy,
    output logic [STALL_CNT_BIT-1:0] stall_cnt
);

    // Local payload layout follows the module parameters, not the package defaults.
    typedef struct packed {
        logic [INST_ID_BIT-1:0] id;
        logic [REG_ID_BIT-1:0]  dst;
        logic [REG_ID_BIT-1:0]  src0;
        logic [REG_ID_BIT-1:0]  src1;
        logic [IMM_BIT-1:0]     imm;
    } payload_t;

    payload_t           out_q;
    logic [NUM_REG-1:0] busy_q;
    logic [NUM_REG-1:0] busy_chk;
    logic [NUM_REG-1:0] busy_d;
    logic [NUM_REG-1:0] wb_oh;
    logic [NUM_REG-1:0] dst_oh;
    logic               raw;
    logic               waw;
    logic               war;
    logic               slot_free;
    logic               accept;
    logic               stall;

    always_comb begin
        wb_oh  = wb_vld ? NUM_REG'(decode(DEC_ID_BIT'(wb_reg))) : '0;
        dst_oh = NUM_REG'(decode(DEC_ID_BIT'(in_dst_reg)));
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        busy_chk = busy_q & ~wb_oh;
`else
        busy_chk = busy_q;
`endif
    end

    hazard_check #(
        .NUM_REG    (NUM_REG),
        .REG_ID_BIT (REG_ID_BIT)
    ) u_hazard_check (
        .busy             (busy_chk),
        .ext_pending_read (ext_pending_read),
        .dst              (in_dst_reg),
        .src0             (in_src_reg0),
        .src1             (in_src_reg1),
        .raw              (raw),
        .waw              (waw),
        .war              (war)
    );

    always_comb begin
        slot_free = !out_vld || out_rdy;
        in_rdy    = in_vld && !raw && !waw && !war && slot_free;
        accept    = in_vld && in_rdy;
        stall     = in_vld && slot_free && !in_rdy;
        // Set is applied after clear so a new writer keeps ownership on a same-edge writeback.
        busy_d    = (busy_q & ~wb_oh) | (accept ? dst_oh : '0);
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            out_vld   <= 1'b0;
            out_q     <= '0;
            stall_cnt <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                out_vld    <= 1'b1;
                out_q.id   <= in_id;
                out_q.dst  <= in_dst_reg;
                out_q.src0 <= in_src_reg0;
                out_q.src1 <= in_src_reg1;
                out_q.imm  <= in_imm;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        reg_busy     = busy_q;
        out_id       = out_q.id;
        out_dst_reg  = out_q.dst;
        out_src_reg0 = out_q.src0;
        out_src_reg1 = out_q.src1;
        out_imm      = out_q.imm;
    end

endmodule
